// File: rtl/osc_clk_div_bank_pkg.sv
// Shared types and defaults for the oscillator clock-enable divider bank.
// Provides the channel mode encoding and the default divisor width and reset divisor.
// Imported by the channel and the top level; it has no ports.
package osc_div_pkg;

  typedef enum logic {
    DIV_PULSE  = 1'b0,  // TICK only, CLKOUT held low
    DIV_TOGGLE = 1'b1   // CLKOUT flips on every TICK, period 2N
  } div_mode_t;

  localparam int DIV_W_DEFAULT    = 16;
  localparam int DIV_INIT_DEFAULT = 50;  // 50 MHz fabric clock -> 1 MHz tick

endpackage

// File: rtl/osc_clk_div_bank_if.sv
// Configuration and output bundle of the divider bank.
// master: drives CFG_* and SYNC and observes TICK/CLKOUT/UPD_PEND (the bus owner).
// slave : the divider bank itself.
interface osc_clk_div_bank_if #(
  parameter int NCH   = 4,
  parameter int DIV_W = 16,
  parameter int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
);
  logic             CFG_WE;
  logic [CH_W-1:0]  CFG_CH;
  logic [DIV_W-1:0] CFG_DIV;
  logic             CFG_MODE;
  logic             CFG_EN;
  logic             SYNC;
  logic [NCH-1:0]   TICK;
  logic [NCH-1:0]   CLKOUT;
  logic [NCH-1:0]   UPD_PEND;

  modport master (
    output CFG_WE, CFG_CH, CFG_DIV, CFG_MODE, CFG_EN, SYNC,
    input  TICK, CLKOUT, UPD_PEND
  );

  modport slave (
    input  CFG_WE, CFG_CH, CFG_DIV, CFG_MODE, CFG_EN, SYNC,
    output TICK, CLKOUT, UPD_PEND
  );
endinterface

// File: rtl/osc_clk_div_bank_chan.sv
// One divider channel: down-counter producing a registered one-cycle TICK every N cycles,
// plus an optional registered square wave that flips on every TICK.
// Ports: clk/rst_n; wr/wr_div/wr_mode/wr_en config write; sync restart; tick/clkout/upd_pend outputs.
module osc_div_chan
  import osc_div_pkg::*;
#(
  parameter int   DIV_W    = DIV_W_DEFAULT,
  parameter int   DIV_INIT = DIV_INIT_DEFAULT,
  parameter logic EN_INIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  input  div_mode_t        wr_mode,
  input  logic             wr_en,
  input  logic             sync,
  output logic             tick,
  output logic             clkout,
  output logic             upd_pend
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] shadow;
  logic [DIV_W-1:0] div_active;
  div_mode_t        mode;
  div_mode_t        shadow_mode;
  logic             en;

  logic [DIV_W-1:0] wr_n;      // written divisor with 0 folded onto 1
  logic             at_wrap;
  logic [DIV_W-1:0] next_div;  // divisor the next reload will use
  div_mode_t        next_mode;

  assign wr_n      = (wr_div == '0) ? DIV_W'(1) : wr_div;
  assign at_wrap   = (cnt == '0);
  assign next_div  = upd_pend ? shadow : div_active;
  assign next_mode = upd_pend ? shadow_mode : mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= DIV_W'(DIV_INIT - 1);
      shadow      <= DIV_W'(DIV_INIT);
      div_active  <= DIV_W'(DIV_INIT);
      mode        <= DIV_PULSE;
      shadow_mode <= DIV_PULSE;
      en          <= EN_INIT;
      tick        <= 1'b0;
      clkout      <= 1'b0;
      upd_pend    <= 1'b0;
    end else if (wr && !wr_en) begin
      // Disable: outputs drop next cycle, counter freezes, new settings take effect at once.
      en          <= 1'b0;
      shadow      <= wr_n;
      div_active  <= wr_n;
      mode        <= wr_mode;
      shadow_mode <= wr_mode;
      upd_pend    <= 1'b0;
      tick        <= 1'b0;
      clkout      <= 1'b0;
    end else if (wr && (!en || sync)) begin
      // Fresh start (or restart under SYNC): nothing is running that could be cut short.
      en          <= 1'b1;
      shadow      <= wr_n;
      div_active  <= wr_n;
      mode        <= wr_mode;
      shadow_mode <= wr_mode;
      cnt         <= wr_n - DIV_W'(1);
      upd_pend    <= 1'b0;
      tick        <= 1'b0;
      clkout      <= 1'b0;
    end else if (en) begin
      if (sync) begin
        div_active <= next_div;
        mode       <= next_mode;
        cnt        <= next_div - DIV_W'(1);
        upd_pend   <= 1'b0;
        tick       <= 1'b0;
        clkout     <= 1'b0;
      end else begin
        tick   <= at_wrap;
        // The edge that ends a period still uses the old mode; a new mode starts with the new period.
        clkout <= (mode == DIV_TOGGLE) ? (clkout ^ at_wrap) : 1'b0;
        if (at_wrap) begin
          div_active <= next_div;
          mode       <= next_mode;
          cnt        <= next_div - DIV_W'(1);
          upd_pend   <= 1'b0;
        end else begin
          cnt <= cnt - DIV_W'(1);
        end
      end
      // Running channel: park the write in the shadow; it outranks a same-cycle pending clear.
      if (wr) begin
        shadow      <= wr_n;
        shadow_mode <= wr_mode;
        upd_pend    <= 1'b1;
      end
    end else begin
      tick   <= 1'b0;
      clkout <= 1'b0;
    end
  end

endmodule

// File: rtl/osc_clk_div_bank.sv
// Bank of NCH programmable clock-enable dividers running off the fabric oscillator clock.
// Decodes CFG_CH into per-channel write strobes and fans SYNC out to every channel.
// Ports: CLK, RESETN (async active-low), bus (slave: CFG_* / SYNC in, TICK/CLKOUT/UPD_PEND out).
module osc_clk_div_bank
  import osc_div_pkg::*;
#(
  parameter int             NCH      = 4,
  parameter int             DIV_W    = DIV_W_DEFAULT,
  parameter int             DIV_INIT = DIV_INIT_DEFAULT,
  parameter logic [NCH-1:0] EN_INIT  = '0
) (
  input  logic               CLK,
  input  logic               RESETN,
  osc_clk_div_bank_if.slave  bus
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0] tick;
  logic [NCH-1:0] clkout;
  logic [NCH-1:0] upd_pend;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    logic wr;
    // Out-of-range channel numbers match no instance, so such writes are dropped.
    assign wr = bus.CFG_WE && (bus.CFG_CH == CH_W'(i));

    osc_div_chan #(
      .DIV_W    (DIV_W),
      .DIV_INIT (DIV_INIT),
      .EN_INIT  (EN_INIT[i])
    ) u_chan (
      .clk      (CLK),
      .rst_n    (RESETN),
      .wr       (wr),
      .wr_div   (bus.CFG_DIV),
      .wr_mode  (div_mode_t'(bus.CFG_MODE)),
      .wr_en    (bus.CFG_EN),
      .sync     (bus.SYNC),
      .tick     (tick[i]),
      .clkout   (clkout[i]),
      .upd_pend (upd_pend[i])
    );
  end

  assign bus.TICK     = tick;
  assign bus.CLKOUT   = clkout;
  assign bus.UPD_PEND = upd_pend;

endmodule

// File: tb/tb_osc_clk_div_bank.sv
// Bench for osc_clk_div_bank: directed scenarios then random config traffic,
// checked every cycle against an event-time reference model (next-tick timestamps per channel).
module tb_osc_clk_div_bank;

  localparam int             NCH      = 3;
  localparam int             DIV_W    = 16;
  localparam int             DIV_INIT = 50;
  localparam logic [NCH-1:0] EN_INIT  = 3'b001;
  localparam int             CH_W     = 2;

  logic CLK;
  logic RESETN;

  osc_clk_div_bank_if #(.NCH(NCH), .DIV_W(DIV_W)) bus ();

  osc_clk_div_bank #(
    .NCH      (NCH),
    .DIV_W    (DIV_W),
    .DIV_INIT (DIV_INIT),
    .EN_INIT  (EN_INIT)
  ) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .bus    (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: each running channel remembers the edge number of its next TICK.
  int cyc;
  bit m_en[NCH], m_mode[NCH], m_pmode[NCH], m_pend[NCH], m_tick[NCH], m_clk[NCH];
  int m_n[NCH], m_pn[NCH], m_wrap[NCH];

  task automatic model_reset();
    cyc = 0;
    for (int i = 0; i < NCH; i++) begin
      m_en[i] = EN_INIT[i]; m_n[i] = DIV_INIT; m_pn[i] = DIV_INIT;
      m_mode[i] = 0; m_pmode[i] = 0; m_pend[i] = 0;
      m_tick[i] = 0; m_clk[i] = 0; m_wrap[i] = DIV_INIT;
    end
  endtask

  task automatic model_edge(input bit we, input int ch, input int dv, input bit md,
                            input bit en, input bit sy);
    int e, nn;
    bit w;
    e  = cyc + 1;
    nn = (dv == 0) ? 1 : dv;
    for (int i = 0; i < NCH; i++) begin
      w = we && (ch == i);
      if (w && !en) begin
        m_en[i] = 0; m_n[i] = nn; m_pn[i] = nn; m_mode[i] = md; m_pmode[i] = md;
        m_pend[i] = 0; m_tick[i] = 0; m_clk[i] = 0;
      end else if (w && (!m_en[i] || sy)) begin
        m_en[i] = 1; m_n[i] = nn; m_pn[i] = nn; m_mode[i] = md; m_pmode[i] = md;
        m_pend[i] = 0; m_tick[i] = 0; m_clk[i] = 0; m_wrap[i] = e + nn;
      end else if (m_en[i]) begin
        if (sy) begin
          if (m_pend[i]) begin m_n[i] = m_pn[i]; m_mode[i] = m_pmode[i]; end
          m_pend[i] = 0; m_tick[i] = 0; m_clk[i] = 0; m_wrap[i] = e + m_n[i];
        end else begin
          m_tick[i] = (e == m_wrap[i]);
          if (m_tick[i]) begin
            m_clk[i] = m_mode[i] ? !m_clk[i] : 1'b0;
            if (m_pend[i]) begin m_n[i] = m_pn[i]; m_mode[i] = m_pmode[i]; end
            m_pend[i] = 0;
            m_wrap[i] = e + m_n[i];
          end else if (!m_mode[i]) begin
            m_clk[i] = 0;
          end
        end
        if (w) begin m_pn[i] = nn; m_pmode[i] = md; m_pend[i] = 1; end
      end else begin
        m_tick[i] = 0; m_clk[i] = 0;
      end
    end
    cyc = e;
  endtask

  task automatic compare_outputs();
    logic [NCH-1:0] et, ec, ep;
    for (int i = 0; i < NCH; i++) begin
      et[i] = m_tick[i]; ec[i] = m_clk[i]; ep[i] = m_pend[i];
    end
    chk("tick", 32'(bus.TICK), 32'(et));
    chk("clkout", 32'(bus.CLKOUT), 32'(ec));
    chk("upd_pend", 32'(bus.UPD_PEND), 32'(ep));
  endtask

  // Drive inputs at a falling edge, advance one rising edge, check at the next falling edge.
  task automatic step(input bit we, input int ch, input int dv, input bit md,
                      input bit en, input bit sy);
    bus.CFG_WE = we; bus.CFG_CH = CH_W'(ch); bus.CFG_DIV = DIV_W'(dv);
    bus.CFG_MODE = md; bus.CFG_EN = en; bus.SYNC = sy;
    model_edge(we, ch, dv, md, en, sy);
    @(negedge CLK);
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int ch, input int dv, input bit md, input bit en);
    step(1, ch, dv, md, en, 0);
  endtask

  task automatic do_reset();
    RESETN = 1'b0;
    bus.CFG_WE = 0; bus.CFG_CH = '0; bus.CFG_DIV = '0;
    bus.CFG_MODE = 0; bus.CFG_EN = 0; bus.SYNC = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_tick", 32'(bus.TICK), 32'h0);
    chk("rst_clkout", 32'(bus.CLKOUT), 32'h0);
    chk("rst_pend", 32'(bus.UPD_PEND), 32'h0);
    RESETN = 1'b1;
    model_reset();
  endtask

  initial begin
    int first, both, ticks, dv;
    do_reset();

    // Reset divisor on enabled channel 0: first TICK 50 edges after release, then every 50.
    first = -1; ticks = 0;
    for (int k = 1; k <= 120; k++) begin
      idle(1);
      if (bus.TICK[0]) begin ticks++; if (first < 0) first = k; end
    end
    chk("first_tick_ch0", first, 50);
    chk("ticks_in_120", ticks, 2);
    chk("pulse_clkout0", bus.CLKOUT[0], 0);

    // Enable ch1 N=4 toggle.
    wr(1, 4, 1, 1);
    first = -1;
    for (int k = 1; k <= 16; k++) begin idle(1); if (first < 0 && bus.TICK[1]) first = k; end
    chk("ch1_first_tick", first, 4);

    // Ch1 at N=10, then retune to 3 mid-period.
    wr(1, 0, 0, 0);
    wr(1, 10, 0, 1);
    idle(14);
    wr(1, 3, 0, 1);
    chk("pend_set", bus.UPD_PEND[1], 1);
    idle(4);
    chk("pend_held", bus.UPD_PEND[1], 1);
    chk("no_runt", bus.TICK[1], 0);
    idle(1);
    chk("pend_clear", bus.UPD_PEND[1], 0);
    chk("wrap_tick", bus.TICK[1], 1);
    first = -1;
    for (int k = 1; k <= 6; k++) begin idle(1); if (first < 0 && bus.TICK[1]) first = k; end
    chk("new_period", first, 3);

    // Phase alignment with SYNC.
    wr(0, 5, 0, 0); wr(0, 5, 0, 1); idle(2); wr(2, 7, 0, 1); idle(3);
    step(0, 0, 0, 0, 0, 1);
    chk("sync_tick_zero", 32'(bus.TICK), 32'h0);
    both = -1;
    for (int k = 1; k <= 40; k++) begin
      idle(1);
      if (both < 0 && bus.TICK[0] && bus.TICK[2]) both = k;
    end
    chk("sync_coincide", both, 35);

    // N=0 on running ch2 (pending until wrap) then stuck high; N=1 toggle on ch0.
    wr(2, 0, 1, 1);
    idle(10);
    chk("n0_stuck", bus.TICK[2], 1);
    wr(0, 1, 0, 0); wr(0, 1, 1, 1);
    idle(6);
    chk("n1_stuck", bus.TICK[0], 1);
    // Out-of-range channel, disable mid-period, SYNC+write on the same cycle.
    step(1, 3, 9, 1, 0, 0);
    idle(4);
    wr(1, 0, 0, 0);
    chk("dis_tick", bus.TICK[1], 0);
    chk("dis_clk", bus.CLKOUT[1], 0);
    idle(3);
    step(1, 2, 6, 0, 1, 1);
    first = -1;
    for (int k = 1; k <= 10; k++) begin idle(1); if (first < 0 && bus.TICK[2]) first = k; end
    chk("sync_we_reload", first, 6);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 5))
          0: dv = 0;
          1: dv = 1;
          default: dv = $urandom_range(2, 12);
        endcase
        step(1, $urandom_range(0, 3), dv, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 4) != 0), ($urandom_range(0, 39) == 0));
      end else begin
        step(0, 0, 0, 0, 0, ($urandom_range(0, 39) == 0));
      end
    end

    // Async reset while ch1 CLKOUT is high two cycles before its wrap.
    wr(1, 0, 1, 0); wr(1, 4, 1, 1);
    for (int k = 0; k < 20 && !(m_tick[1] && m_clk[1]); k++) idle(1);
    idle(1);
    chk("pre_rst_clk1", bus.CLKOUT[1], 1);
    RESETN = 1'b0;
    #1;
    chk("arst_tick", 32'(bus.TICK), 32'h0);
    chk("arst_clkout", 32'(bus.CLKOUT), 32'h0);
    chk("arst_pend", 32'(bus.UPD_PEND), 32'h0);
    do_reset();
    first = -1;
    for (int k = 1; k <= 60; k++) begin idle(1); if (first < 0 && bus.TICK[0]) first = k; end
    chk("post_rst_first", first, 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
